qam_mapper: RTL and testbench

Parametrised constellation mapper for the OFDM modem transmit path; successor to the fixed QPSK mapper. Takes the 2-bit-per-beat stream from the bit-source ROM and builds one symbol from 1, 2 or 3 beats, depending on a run-time mode: QPSK, 16-QAM or 64-QAM. For each symbol it emits one Gray-coded, scaled, signed I/Q pair with a one-cycle valid pulse toward the IFFT loader. Output word width and per-mode amplitude units are parameters.

---
 rtl/qam_mapper.sv | 132 +++++++++++++
 tb/tb_qam_mapper.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/qam_mapper.sv
`default_nettype none
// ============================================================================
// Module   : qam_mapper
// Purpose  : Gray-coded QPSK / 16-QAM / 64-QAM mapper, 1-3 beats per symbol.
// Revision : 1.0
// ============================================================================
module qam_mapper #(
  parameter int OUT_W = 16,
  parameter int U4    = 23170,
  parameter int U16   = 10362,
  parameter int U64   = 4681
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    valid_rom,
  input  logic [1:0]              data_rom,
  input  logic [1:0]              mode,
  input  logic                    sym_sync,
  output logic                    valid_qam,
  output logic signed [OUT_W-1:0] i,
  output logic signed [OUT_W-1:0] q,
  output logic                    frag
);

  localparam int              c_PW     = OUT_W + 3;
  localparam logic [1:0]      c_QPSK   = 2'b00;
  localparam logic [1:0]      c_QAM16  = 2'b01;
  localparam logic [1:0]      c_QAM64  = 2'b10;
  localparam logic [c_PW-1:0] c_U4     = c_PW'(U4);
  localparam logic [c_PW-1:0] c_U16    = c_PW'(U16);
  localparam logic [c_PW-1:0] c_U64    = c_PW'(U64);
  localparam logic [c_PW-1:0] c_MAX    = {4'b0000, {(OUT_W-1){1'b1}}};

  logic [1:0]      r_beat_cnt;
  logic [1:0]      r_mode;
  logic            r_si, r_sq, r_mi, r_mq;

  logic            w_accept, w_beat0, w_resync, w_last;
  logic [1:0]      w_mode, w_idx, w_last_idx;
  logic            w_si, w_sq;
  logic [2:0]      w_lvl_i, w_lvl_q;
  logic [c_PW-1:0] w_unit;

  // Gray magnitude for 64-QAM: {msb,lsb} 00->7, 01->5, 11->3, 10->1
  function automatic logic [2:0] f_lvl64(input logic msb, input logic lsb);
    case ({msb, lsb})
      2'b00:   return 3'd7;
      2'b01:   return 3'd5;
      2'b11:   return 3'd3;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] f_point(input logic neg, input logic [2:0] lvl,
                                               input logic [c_PW-1:0] unit);
    logic [c_PW-1:0] prod;
    logic [c_PW-1:0] mag;
    prod = {{(c_PW-3){1'b0}}, lvl} * unit;
    mag  = (prod > c_MAX) ? c_MAX : prod;
    if (neg) mag = -mag;
    return mag[OUT_W-1:0];
  endfunction

  always_comb begin
    w_accept   = en & valid_rom;
    w_resync   = w_accept & sym_sync & (r_beat_cnt != 2'd0);
    w_beat0    = w_accept & ((r_beat_cnt == 2'd0) | sym_sync);
    w_mode     = r_mode;
    if (w_beat0) w_mode = (mode == 2'b11) ? c_QPSK : mode;
    w_idx      = w_beat0 ? 2'd0 : r_beat_cnt;
    w_last_idx = (w_mode == c_QAM64) ? 2'd2 : (w_mode == c_QAM16) ? 2'd1 : 2'd0;
    w_last     = w_accept & (w_idx == w_last_idx);
    // The sign beat is the current one only for QPSK
    w_si       = (w_idx == 2'd0) ? data_rom[1] : r_si;
    w_sq       = (w_idx == 2'd0) ? data_rom[0] : r_sq;
    w_lvl_i    = 3'd1;
    w_lvl_q    = 3'd1;
    w_unit     = c_U4;
    case (w_mode)
      c_QAM16: begin
        w_lvl_i = data_rom[1] ? 3'd1 : 3'd3;
        w_lvl_q = data_rom[0] ? 3'd1 : 3'd3;
        w_unit  = c_U16;
      end
      c_QAM64: begin
        w_lvl_i = f_lvl64(r_mi, data_rom[1]);
        w_lvl_q = f_lvl64(r_mq, data_rom[0]);
        w_unit  = c_U64;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= 2'd0;
      r_mode     <= c_QPSK;
      r_si       <= 1'b0;
      r_sq       <= 1'b0;
      r_mi       <= 1'b0;
      r_mq       <= 1'b0;
      valid_qam  <= 1'b0;
      frag       <= 1'b0;
      i          <= '0;
      q          <= '0;
    end else begin
      valid_qam <= w_last;
      frag      <= w_resync;
      if (w_accept) begin
        if (w_beat0) r_mode <= w_mode;
        if (w_last) begin
          r_beat_cnt <= 2'd0;
          i          <= f_point(w_si, w_lvl_i, w_unit);
          q          <= f_point(w_sq, w_lvl_q, w_unit);
        end else begin
          r_beat_cnt <= w_idx + 2'd1;
        end
        if (w_idx == 2'd0) begin
          r_si <= data_rom[1];
          r_sq <= data_rom[0];
        end
        if (w_idx == 2'd1) begin
          r_mi <= data_rom[1];
          r_mq <= data_rom[0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qam_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_mapper
// Purpose  : Directed vector bench for qam_mapper (default and U64=5000).
// Revision : 1.0
// ============================================================================
module tb_qam_mapper;

  logic clk = 1'b0;
  logic rst, en, valid_rom, sym_sync;
  logic [1:0] data_rom, mode;
  logic valid_qam, frag, valid_s, frag_s;
  logic signed [15:0] i, q, i_s, q_s;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       vr;
    logic [1:0] data;
    logic [1:0] mode;
    logic       sync;
    logic       ev;
    logic       ef;
    int         ei;
    int         eq;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  qam_mapper dut (
    .clk(clk), .rst(rst), .en(en), .valid_rom(valid_rom), .data_rom(data_rom),
    .mode(mode), .sym_sync(sym_sync), .valid_qam(valid_qam), .i(i), .q(q), .frag(frag)
  );

  qam_mapper #(.U64(5000)) dut_s (
    .clk(clk), .rst(rst), .en(en), .valid_rom(valid_rom), .data_rom(data_rom),
    .mode(mode), .sym_sync(sym_sync), .valid_qam(valid_s), .i(i_s), .q(q_s), .frag(frag_s)
  );

  task automatic add(input logic e, input logic vr, input logic [1:0] d, input logic [1:0] m,
                     input logic s, input logic ev, input logic ef, input int ei, input int eq);
    tbl.push_back('{e, vr, d, m, s, ev, ef, ei, eq});
  endtask

  task automatic drive(input logic e, input logic vr, input logic [1:0] d,
                       input logic [1:0] m, input logic s);
    en = e; valid_rom = vr; data_rom = d; mode = m; sym_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic f, input int ei, input int eq);
    n_vec++;
    if (valid_qam !== v || frag !== f || int'(i) != ei || int'(q) != eq) begin
      n_bad++;
      $display("FAIL %s: got valid=%b frag=%b i=%0d q=%0d, want valid=%b frag=%b i=%0d q=%0d",
               name, valid_qam, frag, i, q, v, f, ei, eq);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid_rom = 1'b0; data_rom = 2'b00; mode = 2'b00; sym_sync = 1'b0;

    // QPSK back-to-back
    add(1,1,2'b00,2'b00,0, 1,0,  23170,  23170);
    add(1,1,2'b10,2'b00,0, 1,0, -23170,  23170);
    add(1,1,2'b01,2'b00,0, 1,0,  23170, -23170);
    add(1,1,2'b11,2'b00,0, 1,0, -23170, -23170);
    // 16-QAM
    add(1,1,2'b01,2'b01,0, 0,0, -23170, -23170);
    add(1,1,2'b10,2'b01,0, 1,0,  10362, -31086);
    // 64-QAM full scale, then mixed levels
    add(1,1,2'b00,2'b10,0, 0,0,  10362, -31086);
    add(1,1,2'b00,2'b10,0, 0,0,  10362, -31086);
    add(1,1,2'b00,2'b10,0, 1,0,  32767,  32767);
    add(1,1,2'b11,2'b10,0, 0,0,  32767,  32767);
    add(1,1,2'b10,2'b10,0, 0,0,  32767,  32767);
    add(1,1,2'b10,2'b10,0, 1,0, -14043, -32767);
    // Stall with mid-symbol mode change
    add(1,1,2'b11,2'b01,0, 0,0, -14043, -32767);
    for (int k = 0; k < 5; k++) add(0,1,2'b00,2'b10,0, 0,0, -14043, -32767);
    add(1,0,2'b00,2'b10,0, 0,0, -14043, -32767);
    add(1,1,2'b01,2'b10,0, 1,0, -31086, -10362);
    add(1,1,2'b00,2'b10,0, 0,0, -31086, -10362);
    add(1,1,2'b00,2'b10,0, 0,0, -31086, -10362);
    add(1,1,2'b01,2'b10,0, 1,0,  32767,  23405);
    // Resync in 64-QAM
    add(1,1,2'b00,2'b10,0, 0,0,  32767,  23405);
    add(1,1,2'b11,2'b10,0, 0,0,  32767,  23405);
    add(1,1,2'b11,2'b10,1, 0,1,  32767,  23405);
    add(1,1,2'b00,2'b10,0, 0,0,  32767,  23405);
    add(1,1,2'b11,2'b10,0, 1,0, -23405, -23405);
    // Resync into QPSK: frag and valid on the same edge
    add(1,1,2'b00,2'b01,0, 0,0, -23405, -23405);
    add(1,1,2'b10,2'b00,1, 1,1, -23170,  23170);
    // sync at a boundary is harmless; reserved mode acts as QPSK
    add(1,1,2'b01,2'b00,1, 1,0,  23170, -23170);
    add(1,1,2'b11,2'b11,0, 1,0, -23170, -23170);

    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].vr, tbl[k].data, tbl[k].mode, tbl[k].sync);
      check($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ef, tbl[k].ei, tbl[k].eq);
    end

    // Saturation with a larger 64-QAM unit
    drive(1, 1, 2'b01, 2'b10, 0);
    drive(1, 1, 2'b00, 2'b10, 0);
    drive(1, 1, 2'b00, 2'b10, 0);
    check("sat_ref", 1'b1, 1'b0, 32767, -32767);
    n_vec++;
    if (valid_s !== 1'b1 || frag_s !== 1'b0 || int'(i_s) != 32767 || int'(q_s) != -32767) begin
      n_bad++;
      $display("FAIL sat_u5000: got valid=%b i=%0d q=%0d, want valid=1 i=32767 q=-32767",
               valid_s, i_s, q_s);
    end

    // Asynchronous reset mid 16-QAM symbol
    drive(1, 1, 2'b11, 2'b01, 0);
    check("pre_rst", 1'b0, 1'b0, 32767, -32767);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 2'b10, 2'b00, 0);
    check("post_rst_qpsk", 1'b1, 1'b0, -23170, 23170);
    drive(1, 1, 2'b01, 2'b01, 0);
    check("post_rst_q16a", 1'b0, 1'b0, -23170, 23170);
    drive(1, 1, 2'b10, 2'b01, 0);
    check("post_rst_q16b", 1'b1, 1'b0, 10362, -31086);
    drive(0, 0, 2'b00, 2'b00, 0);
    check("idle", 1'b0, 1'b0, 10362, -31086);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
